read_counter: RTL and testbench
===============================

# read_counter

Digital read counter for one CDU channel: the consumer of the main summing amplifier's Schmitt-trigger outputs and the driver of its ladder switch bits. It steps a 16-bit angle counter up or down at a high or low rate, as selected by the fine-error thresholds, until the ladder feedback nulls the error. Each step is also queued as a ±1 increment toward the AGC through a bounded pending buffer with a request/ack handshake.

## Interface
- HS_DIV, 4: WAIT length in clocks when the high-rate threshold is active (≥1)
- LS_DIV, 64: WAIT length in clocks when only the low-rate threshold is active (≥ HS_DIV)
- SETTLE_CYC, 2: clocks held after each step for ladder/amplifier settling (≥0)
- PEND_MAX, 7: magnitude limit of the pending AGC increment count (1..127)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- _TLF1H  in  1  fine error above +low threshold
- _TLF2H  in  1  fine error above +high threshold
- _TLF1L  in  1  fine error below −low threshold
- _TLF2L  in  1  fine error below −high threshold
- agc_ack  in  1  one-cycle pulse; the AGC consumed one pending increment
- cnt  out  16  read counter value, an angle modulo 2^16
- _D15.._D21  out  1 each  ladder bits, active-low: _D15 = ~cnt[6] … _D21 = ~cnt[0]
- agc_up  out  1  pending count > 0
- agc_dn  out  1  pending count < 0

## Operation
- Qualified inputs:
  - up = _TLF1H | _TLF2H; dn = _TLF1L | _TLF2L; hi = _TLF2H | _TLF2L.
  - up & dn together is invalid and is treated as no threshold.
  - dir = +1 for up, −1 for dn.
- FSM states: IDLE, WAIT, STEP, SETTLE.
  - IDLE: a valid threshold latches dir and loads timer = (hi ? HS_DIV : LS_DIV) − 1, then goes to WAIT. Otherwise stays in IDLE.
  - WAIT: decrements timer while timer > 0.
    - Threshold lost or dir reversed → IDLE, no step.
    - hi becomes active → timer = min(timer, HS_DIV−1).
    - hi drops while the low threshold remains → keeps the current timer.
    - timer == 0 → STEP, unless pending is at the limit in dir (+PEND_MAX for up, −PEND_MAX for dn). In that case it stays in WAIT with timer held at 0 (backpressure).
  - STEP: one cycle. cnt ← cnt + dir, wrapping 0xFFFF↔0x0000. Pending ← pending + dir. Go to SETTLE, or straight to IDLE when SETTLE_CYC = 0.
  - SETTLE: SETTLE_CYC cycles; thresholds are ignored. Then → IDLE.
- Pending buffer:
  - Signed count in [−PEND_MAX, +PEND_MAX].
  - agc_ack with pending ≠ 0 moves pending one toward zero. agc_ack with pending = 0 is ignored.
  - Same-cycle step and ack: next = pending + dir − sign(pending).
- Reset values (asynchronous clear of all state):
  - cnt = 0, so all _Dxx = 1.
  - pending = 0, so agc_up = agc_dn = 0.
  - FSM = IDLE, timer = 0.
  - Synchronizers cleared.

## Timing
- All outputs are registered.
- Synchronized inputs (see Configuration) are visible to the FSM after the synchronizer latency L.
- Continuous threshold, no backpressure:
  - First cnt change occurs L + DIV + 2 edges after the input rises.
  - Steady step period is DIV + 2 + SETTLE_CYC clocks: 8 for high rate, 68 for low rate at the defaults.
- agc_up/agc_dn update on the edge that ends STEP, or on the edge that samples agc_ack.

## Configuration
- RDCNT_SYNC_EN defined: each of the four threshold inputs passes through a two-flop synchronizer, so L = 2.
- Undefined: inputs are sampled directly by the FSM, so L = 0. Used for simulation with the ideal analog models.
- No other behaviour changes.

## Structure
- Shared package cdu_pkg holds:
  - the rdcnt_state_t enum (IDLE, WAIT, STEP, SETTLE)
  - the dir_t encoding (+1/−1)
  - the CNT_W = 16 constant
  - the ladder bit map constants (D15 → bit 6 … D21 → bit 0)
- One sub-module, rdcnt_pend, contains the saturating pending counter, the handshake outputs and the "full in dir" flag.
- The FSM, timer and cnt stay in read_counter.

## Test plan
- Reset, then hold _TLF2H = 1 with no acks → cnt = 1 at edge L+6. Steps continue every 8 clocks until pending = +7, then cnt holds at 7 with agc_up = 1.
- Preload cnt = 0xFFFF via steps, then _TLF1H with acks returned → cnt wraps to 0x0000. At cnt = 0x0000, _D15.._D21 all read 1.
- _TLF1L held, then _TLF2L asserts mid-WAIT with timer = 40 → timer clamps to 3 and the step lands 4 clocks later. cnt decrements; agc_dn = 1.
- _TLF1H and _TLF1L asserted together for 100 clocks → no step; FSM stays in IDLE.
- With pending = +1, a STEP down and agc_ack occur in the same cycle → pending = −1, agc_dn = 1.
- rst asserted mid-WAIT, and again during SETTLE → all outputs immediately at reset values; a pending step is never taken.

Source files
------------

// File: rtl/cdu_pkg.sv
// Shared CDU definitions: read-counter FSM states, step direction encoding,
// counter width and the ladder-switch bit map.
package cdu_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, STEP, SETTLE} rdcnt_state_t;

  // Two's-complement style: 01 = +1, 11 = -1
  typedef enum logic [1:0] {DIR_UP = 2'b01, DIR_DN = 2'b11} dir_t;

  // Ladder switch bits, active-low, MSB switch D15 driven from cnt[6]
  localparam int D15_BIT = 6;
  localparam int D16_BIT = 5;
  localparam int D17_BIT = 4;
  localparam int D18_BIT = 3;
  localparam int D19_BIT = 2;
  localparam int D20_BIT = 1;
  localparam int D21_BIT = 0;
endpackage

// File: rtl/rdcnt_pend.sv
// Pending AGC increment buffer: signed count bounded to +/-PEND_MAX,
// drained one unit per agc_ack, with registered up/down request flags.
module rdcnt_pend
  import cdu_pkg::*;
#(
  parameter int PEND_MAX = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  input  dir_t i_dir,
  input  logic i_ack,
  output logic o_up,
  output logic o_dn,
  output logic o_full
);
  localparam logic signed [7:0] PMAX = 8'(PEND_MAX);
  localparam logic signed [7:0] NMAX = 8'(-PEND_MAX);

  logic signed [7:0] r_pend;
  logic signed [7:0] w_stp, w_ack, w_next;
  logic              r_up, r_dn;

  // next count: step adds dir, ack pulls one toward zero (ignored at zero)
  always_comb begin
    w_stp  = i_step ? ((i_dir == DIR_UP) ? 8'sd1 : -8'sd1) : 8'sd0;
    w_ack  = 8'sd0;
    if (i_ack && (r_pend > 8'sd0)) w_ack = 8'sd1;
    if (i_ack && (r_pend < 8'sd0)) w_ack = -8'sd1;
    w_next = r_pend + w_stp - w_ack;
  end

  // count and request flags registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_up   <= 1'b0;
      r_dn   <= 1'b0;
    end else begin
      r_pend <= w_next;
      r_up   <= (w_next > 8'sd0);
      r_dn   <= (w_next < 8'sd0);
    end
  end

  assign o_up   = r_up;
  assign o_dn   = r_dn;
  assign o_full = (i_dir == DIR_UP) ? (r_pend >= PMAX) : (r_pend <= NMAX);
endmodule

// File: rtl/read_counter.sv
// CDU read counter: steps a 16-bit angle counter toward null at a high or
// low rate chosen by the fine-error thresholds, drives the ladder bits and
// queues each step toward the AGC.
// Define RDCNT_SYNC_EN to pass the threshold inputs through 2-flop
// synchronizers (2 clocks of added input latency).
module read_counter
  import cdu_pkg::*;
#(
  parameter int HS_DIV     = 4,
  parameter int LS_DIV     = 64,
  parameter int SETTLE_CYC = 2,
  parameter int PEND_MAX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             _TLF1H,
  input  logic             _TLF2H,
  input  logic             _TLF1L,
  input  logic             _TLF2L,
  input  logic             agc_ack,
  output logic [CNT_W-1:0] cnt,
  output logic             _D15,
  output logic             _D16,
  output logic             _D17,
  output logic             _D18,
  output logic             _D19,
  output logic             _D20,
  output logic             _D21,
  output logic             agc_up,
  output logic             agc_dn
);
  localparam logic [15:0] HS_LD = 16'(HS_DIV - 1);
  localparam logic [15:0] LS_LD = 16'(LS_DIV - 1);
  localparam logic [15:0] ST_LD = 16'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  logic [3:0]       w_thr_raw, w_thr;
  logic             w_up, w_dn, w_hi, w_valid, w_full, w_step;
  dir_t             w_dir, r_dir, w_dir_nxt;
  rdcnt_state_t     r_state, w_state_nxt;
  logic [15:0]      r_timer, w_timer_nxt, r_settle, w_settle_nxt;
  logic [CNT_W-1:0] r_cnt;

  assign w_thr_raw = {_TLF2L, _TLF1L, _TLF2H, _TLF1H};

`ifdef RDCNT_SYNC_EN
  logic [3:0] r_sync1, r_sync2;
  // two-flop synchronizer on the asynchronous comparator outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_thr_raw;
      r_sync2 <= r_sync1;
    end
  end
  assign w_thr = r_sync2;
`else
  assign w_thr = w_thr_raw;
`endif

  // up and dn together is an invalid comparator state: treat as no threshold
  assign w_up    = w_thr[0] | w_thr[1];
  assign w_dn    = w_thr[2] | w_thr[3];
  assign w_hi    = w_thr[1] | w_thr[3];
  assign w_valid = w_up ^ w_dn;
  assign w_dir   = w_up ? DIR_UP : DIR_DN;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state plus timer/settle/direction updates
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_settle_nxt = r_settle;
    w_dir_nxt    = r_dir;
    case (r_state)
      IDLE: if (w_valid) begin
        w_state_nxt = WAIT;
        w_dir_nxt   = w_dir;
        w_timer_nxt = w_hi ? HS_LD : LS_LD;
      end
      WAIT: begin
        if (!w_valid || (w_dir != r_dir)) begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == '0) begin
          // hold at zero while the AGC buffer is full in this direction
          if (!w_full) w_state_nxt = STEP;
        end else if (w_hi && (r_timer > HS_LD)) begin
          w_timer_nxt = HS_LD;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      STEP: begin
        if (SETTLE_CYC == 0) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = ST_LD;
        end
      end
      SETTLE: begin
        if (r_settle == '0) w_state_nxt = IDLE;
        else                w_settle_nxt = r_settle - 16'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    w_step = (r_state == STEP);
  end

  // datapath registers: timer, settle count, latched direction, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer  <= '0;
      r_settle <= '0;
      r_dir    <= DIR_UP;
      r_cnt    <= '0;
    end else begin
      r_timer  <= w_timer_nxt;
      r_settle <= w_settle_nxt;
      r_dir    <= w_dir_nxt;
      if (w_step) r_cnt <= r_cnt + ((r_dir == DIR_UP) ? 16'd1 : 16'hFFFF);
    end
  end

  rdcnt_pend #(.PEND_MAX(PEND_MAX)) u_pend (
    .clk    (clk),
    .rst    (rst),
    .i_step (w_step),
    .i_dir  (r_dir),
    .i_ack  (agc_ack),
    .o_up   (agc_up),
    .o_dn   (agc_dn),
    .o_full (w_full)
  );

  assign cnt  = r_cnt;
  assign _D15 = ~r_cnt[D15_BIT];
  assign _D16 = ~r_cnt[D16_BIT];
  assign _D17 = ~r_cnt[D17_BIT];
  assign _D18 = ~r_cnt[D18_BIT];
  assign _D19 = ~r_cnt[D19_BIT];
  assign _D20 = ~r_cnt[D20_BIT];
  assign _D21 = ~r_cnt[D21_BIT];
endmodule

// File: tb/tb_read_counter.sv
// Directed bench for read_counter at default parameters.
module tb_read_counter;
`ifdef RDCNT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        _TLF1H = 0, _TLF2H = 0, _TLF1L = 0, _TLF2L = 0, agc_ack = 0;
  logic [15:0] cnt;
  logic        _D15, _D16, _D17, _D18, _D19, _D20, _D21, agc_up, agc_dn;
  logic [6:0]  dbits;
  int          checks = 0, failures = 0;
  logic        found;

  read_counter dut (
    .clk(clk), .rst(rst),
    ._TLF1H(_TLF1H), ._TLF2H(_TLF2H), ._TLF1L(_TLF1L), ._TLF2L(_TLF2L),
    .agc_ack(agc_ack), .cnt(cnt),
    ._D15(_D15), ._D16(_D16), ._D17(_D17), ._D18(_D18),
    ._D19(_D19), ._D20(_D20), ._D21(_D21),
    .agc_up(agc_up), .agc_dn(agc_dn)
  );

  assign dbits = {_D15, _D16, _D17, _D18, _D19, _D20, _D21};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(2);
    chk("rst_cnt", cnt, 16'h0000);
    chk("rst_dbits", dbits, 7'h7F);
    chk("rst_up", agc_up, 0);
    chk("rst_dn", agc_dn, 0);
    rst = 1'b0;
    tick(2);
    // ack with empty buffer is ignored
    agc_ack = 1; tick(1); agc_ack = 0;
    chk("ack0_up", agc_up, 0);
    chk("ack0_dn", agc_dn, 0);
    tick(2);

    // high rate up: first step at L+6, period 8, stall at pending +7
    _TLF2H = 1;
    tick(L + 5); chk("hs_pre", cnt, 16'd0);
    tick(1);     chk("hs_first", cnt, 16'd1);
    tick(8);     chk("hs_second", cnt, 16'd2);
    tick(40);    chk("hs_seventh", cnt, 16'd7);
    chk("hs_up", agc_up, 1);
    tick(40);    chk("bp_hold", cnt, 16'd7);
    chk("bp_up", agc_up, 1);

    // step down 8 times to 0xFFFF (pending 7 -> -1)
    _TLF2H = 0; _TLF2L = 1; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1);
      if (cnt == 16'hFFFF) found = 1;
    end
    _TLF2L = 0;
    chk("wrap_reach", found, 1);
    chk("neg_dn", agc_dn, 1);
    agc_ack = 1; tick(1); agc_ack = 0;
    chk("ack_dn", agc_dn, 0);
    chk("ack_up", agc_up, 0);
    tick(5);

    // low rate up, wraps 0xFFFF -> 0x0000 after LS_DIV+2 edges
    _TLF1H = 1;
    tick(L + 65); chk("ls_pre", cnt, 16'hFFFF);
    tick(1);      chk("ls_wrap", cnt, 16'h0000);
    chk("wrap_dbits", dbits, 7'h7F);
    chk("wrap_up", agc_up, 1);
    _TLF1H = 0;
    agc_ack = 1; tick(1); agc_ack = 0;
    chk("wrap_ack", agc_up, 0);
    tick(5);

    // low rate down, high threshold joins with timer at 40 -> clamp to 3
    _TLF1L = 1;
    tick(24); _TLF2L = 1;
    tick(L + 5); chk("clamp_pre", cnt, 16'h0000);
    tick(1);     chk("clamp_step", cnt, 16'hFFFF);
    chk("clamp_dn", agc_dn, 1);
    _TLF1L = 0; _TLF2L = 0;
    tick(5);

    // invalid up+dn: no step for 100 clocks
    _TLF1H = 1; _TLF1L = 1;
    tick(100);
    chk("inv_cnt", cnt, 16'hFFFF);
    chk("inv_dn", agc_dn, 1);
    _TLF1H = 0; _TLF1L = 0;
    tick(2);

    // build pending = +1, then STEP down with same-cycle ack -> -1
    agc_ack = 1; tick(1); agc_ack = 0;
    chk("p0_dn", agc_dn, 0);
    _TLF2H = 1; tick(L + 6); _TLF2H = 0;
    chk("p1_cnt", cnt, 16'h0000);
    chk("p1_up", agc_up, 1);
    tick(5);
    _TLF2L = 1;
    tick(L + 5);
    agc_ack = 1; tick(1); agc_ack = 0; _TLF2L = 0;
    chk("same_cnt", cnt, 16'hFFFF);
    chk("same_dn", agc_dn, 1);
    chk("same_up", agc_up, 0);
    tick(5);

    // reset mid-WAIT
    _TLF1L = 1; tick(10);
    #2 rst = 1; #1;
    chk("rw_cnt", cnt, 16'h0000);
    chk("rw_dbits", dbits, 7'h7F);
    chk("rw_dn", agc_dn, 0);
    _TLF1L = 0;
    tick(2); rst = 0;
    tick(100);
    chk("rw_after", cnt, 16'h0000);

    // reset during SETTLE
    _TLF2H = 1; tick(L + 6);
    chk("rs_pre", cnt, 16'd1);
    #2 rst = 1; #1;
    chk("rs_cnt", cnt, 16'h0000);
    chk("rs_up", agc_up, 0);
    _TLF2H = 0;
    tick(2); rst = 0;
    tick(20);
    chk("rs_after", cnt, 16'h0000);
    chk("rs_after_up", agc_up, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
